// File: rtl/triangle_scan_pkg.sv
// triangle_scan_pkg
// Shared definitions for the triangle rasteriser slice.
//   CW       coordinate width (unsigned, 0 .. 2^CW-1)
//   NW       inside-pixel counter width (holds up to 2^(2*CW))
//   coord_t  one coordinate
//   state_t  scan controller states
//   min3 / max3  unsigned min/max of three coordinates, kept here so later
//                rasterisation stages can reuse them
package triangle_scan_pkg;

  localparam int CW = 12;
  localparam int NW = 2 * CW + 1;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    BBOX,
    SCAN,
    FLUSH
  } state_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/triangle_scan_if.sv
// triangle_scan_if
// Inside-point stream leaving the scanner (valid/ready).
//   out_valid  inside point available
//   out_ready  consumer accepts the point this cycle
//   out_x/y    coordinates of the inside point
// Modports: master = scanner side, slave = consumer side.
interface triangle_scan_if;
  import triangle_scan_pkg::*;

  logic   out_valid;
  logic   out_ready;
  coord_t out_x;
  coord_t out_y;

  modport master (
    output out_valid,
    output out_x,
    output out_y,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_x,
    input  out_y,
    output out_ready
  );

endinterface

// File: rtl/triangle_scan_bbox.sv
// tri_bbox
// Purely combinational bounding box of three vertices. The parent registers
// the result during its BBOX cycle.
//   x1,y1,x2,y2,x3,y3  in   vertex coordinates
//   xmin,xmax          out  unsigned min/max of the x coordinates
//   ymin,ymax          out  unsigned min/max of the y coordinates
module tri_bbox
  import triangle_scan_pkg::*;
(
  input  coord_t x1,
  input  coord_t y1,
  input  coord_t x2,
  input  coord_t y2,
  input  coord_t x3,
  input  coord_t y3,
  output coord_t xmin,
  output coord_t xmax,
  output coord_t ymin,
  output coord_t ymax
);

  assign xmin = min3(x1, x2, x3);
  assign xmax = max3(x1, x2, x3);
  assign ymin = min3(y1, y2, y3);
  assign ymax = max3(y1, y2, y3);

endmodule

// File: rtl/triangle_scan.sv
// triangle_scan
// Feeds every integer point of a triangle's bounding box, one per cycle, to
// an external combinational point-in-triangle tester and streams the points
// the tester reports as inside. Counts the inside points of each job.
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               job request, only accepted while idle
//   x1..y3              triangle vertices, sampled when start is accepted
//   busy                high whenever a job is in progress
//   t_x1..t_y3          latched vertices, wired to the tester
//   probe_x, probe_y    current test point, wired to the tester
//   probe_inside        tester verdict for the current probe (same cycle)
//   out_if              inside-point stream (valid/ready, x, y)
//   pix_count           inside points of the current / last job
//   done                one-cycle pulse when a job finishes
module triangle_scan
  import triangle_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  coord_t            x1,
  input  coord_t            y1,
  input  coord_t            x2,
  input  coord_t            y2,
  input  coord_t            x3,
  input  coord_t            y3,
  output logic              busy,
  output coord_t            t_x1,
  output coord_t            t_y1,
  output coord_t            t_x2,
  output coord_t            t_y2,
  output coord_t            t_x3,
  output coord_t            t_y3,
  output coord_t            probe_x,
  output coord_t            probe_y,
  input  logic              probe_inside,
  triangle_scan_if.master   out_if,
  output logic [NW-1:0]     pix_count,
  output logic              done
);

  state_t state;

  coord_t bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  coord_t xmin_reg, xmax_reg, ymin_reg;
  coord_t ymax_reg;

  logic   valid_reg;
  coord_t x_reg;
  coord_t y_reg;

  logic   stall;
  logic   handshake;

  tri_bbox u_bbox (
    .x1   (t_x1),
    .y1   (t_y1),
    .x2   (t_x2),
    .y2   (t_y2),
    .x3   (t_x3),
    .y3   (t_y3),
    .xmin (bb_xmin),
    .xmax (bb_xmax),
    .ymin (bb_ymin),
    .ymax (bb_ymax)
  );

  assign out_if.out_valid = valid_reg;
  assign out_if.out_x     = x_reg;
  assign out_if.out_y     = y_reg;

  assign handshake = valid_reg && out_if.out_ready;
  // An inside probe cannot be captured while the previous point still waits.
  assign stall     = probe_inside && valid_reg && !out_if.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      t_x1      <= '0;
      t_y1      <= '0;
      t_x2      <= '0;
      t_y2      <= '0;
      t_x3      <= '0;
      t_y3      <= '0;
      xmin_reg  <= '0;
      xmax_reg  <= '0;
      ymin_reg  <= '0;
      ymax_reg  <= '0;
      probe_x   <= '0;
      probe_y   <= '0;
      valid_reg <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      pix_count <= '0;
    end else begin
      done <= 1'b0;

      // Drain the output register; a capture below overrides this.
      if (handshake) begin
        valid_reg <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            t_x1      <= x1;
            t_y1      <= y1;
            t_x2      <= x2;
            t_y2      <= y2;
            t_x3      <= x3;
            t_y3      <= y3;
            pix_count <= '0;
            busy      <= 1'b1;
            state     <= BBOX;
          end
        end

        BBOX: begin
          xmin_reg <= bb_xmin;
          xmax_reg <= bb_xmax;
          ymin_reg <= bb_ymin;
          ymax_reg <= bb_ymax;
          probe_x  <= bb_xmin;
          probe_y  <= bb_ymin;
          state    <= SCAN;
        end

        SCAN: begin
          if (!stall) begin
            if (probe_inside) begin
              x_reg     <= probe_x;
              y_reg     <= probe_y;
              valid_reg <= 1'b1;
              pix_count <= pix_count + NW'(1);
            end
            // Row-major walk; the last point ends the scan instead of
            // stepping, so the probe never passes xmax/ymax.
            if (probe_x == xmax_reg) begin
              if (probe_y == ymax_reg) begin
                state <= FLUSH;
              end else begin
                probe_x <= xmin_reg;
                probe_y <= probe_y + CW'(1);
              end
            end else begin
              probe_x <= probe_x + CW'(1);
            end
          end
        end

        FLUSH: begin
          if (!valid_reg || out_if.out_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_scan.sv
// tb_triangle_scan
// Self-checking bench for triangle_scan. An inclusive-edge point-in-triangle
// model plays the external tester; the expected inside points of each job
// come from enumerating the bounding box with plain arithmetic.
module tb_triangle_scan;
  import triangle_scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [CW-1:0] x1, y1, x2, y2, x3, y3;
  logic          busy;
  logic          done;
  logic [CW-1:0] t_x1, t_y1, t_x2, t_y2, t_x3, t_y3;
  logic [CW-1:0] probe_x, probe_y;
  logic          probe_inside;
  logic [NW-1:0] pix_count;
  bit            stub_mode = 1'b0;

  triangle_scan_if sif();

  triangle_scan dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .x1           (x1),
    .y1           (y1),
    .x2           (x2),
    .y2           (y2),
    .x3           (x3),
    .y3           (y3),
    .busy         (busy),
    .t_x1         (t_x1),
    .t_y1         (t_y1),
    .t_x2         (t_x2),
    .t_y2         (t_y2),
    .t_x3         (t_x3),
    .t_y3         (t_y3),
    .probe_x      (probe_x),
    .probe_y      (probe_y),
    .probe_inside (probe_inside),
    .out_if       (sif),
    .pix_count    (pix_count),
    .done         (done)
  );

  // Inclusive-edge test: a point is inside when it is on the same side of
  // (or on) all three edges.
  function automatic bit tri_inside(input int ax, input int ay, input int bx, input int by,
                                    input int cx, input int cy, input int px, input int py);
    longint d1, d2, d3;
    d1 = longint'(bx - ax) * (py - ay) - longint'(by - ay) * (px - ax);
    d2 = longint'(cx - bx) * (py - by) - longint'(cy - by) * (px - bx);
    d3 = longint'(ax - cx) * (py - cy) - longint'(ay - cy) * (px - cx);
    return (d1 >= 0 && d2 >= 0 && d3 >= 0) || (d1 <= 0 && d2 <= 0 && d3 <= 0);
  endfunction

  // The tester sees the vertices the DUT latched, like the real system.
  always_comb begin
    if (stub_mode)
      probe_inside = (probe_y == '0) && (probe_x < CW'(3));
    else
      probe_inside = tri_inside(int'(t_x1), int'(t_y1), int'(t_x2), int'(t_y2),
                                int'(t_x3), int'(t_y3), int'(probe_x), int'(probe_y));
  end

  typedef struct {
    int x1, y1, x2, y2, x3, y3;
    int rdy_mode;
    bit extra_start;
    int exp_count;
    int exp_fx, exp_fy, exp_lx, exp_ly;
    int exp_done;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int got_x[$], got_y[$];
  int exp_x[$], exp_y[$];
  int done_cyc, last_hs, probe_err;

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic applyStimulus(input vec_t v);
    int xmn, xmx, ymn, ymx, w, h, idx, budget, ex, ey;
    xmn = v.x1; if (v.x2 < xmn) xmn = v.x2; if (v.x3 < xmn) xmn = v.x3;
    xmx = v.x1; if (v.x2 > xmx) xmx = v.x2; if (v.x3 > xmx) xmx = v.x3;
    ymn = v.y1; if (v.y2 < ymn) ymn = v.y2; if (v.y3 < ymn) ymn = v.y3;
    ymx = v.y1; if (v.y2 > ymx) ymx = v.y2; if (v.y3 > ymx) ymx = v.y3;
    w = xmx - xmn + 1;
    h = ymx - ymn + 1;
    exp_x.delete(); exp_y.delete();
    for (int yy = ymn; yy <= ymx; yy++)
      for (int xx = xmn; xx <= xmx; xx++)
        if (tri_inside(v.x1, v.y1, v.x2, v.y2, v.x3, v.y3, xx, yy)) begin
          exp_x.push_back(xx);
          exp_y.push_back(yy);
        end
    got_x.delete(); got_y.delete();
    done_cyc  = -1;
    last_hs   = -1;
    probe_err = 0;
    idx       = 0;
    budget    = 20 + 8 * w * h;

    @(negedge clk);
    x1 = CW'(v.x1); y1 = CW'(v.y1); x2 = CW'(v.x2);
    y2 = CW'(v.y2); x3 = CW'(v.x3); y3 = CW'(v.y3);
    start = 1'b1;
    sif.out_ready = rdy(v.rdy_mode, 0);
    for (int k = 0; k < budget; k++) begin
      if (k >= 2 && idx < w * h) begin
        ex = xmn + idx % w;
        ey = ymn + idx / w;
        if (int'(probe_x) != ex || int'(probe_y) != ey) probe_err++;
        if (!(probe_inside && sif.out_valid && !sif.out_ready)) idx++;
      end
      if (sif.out_valid && sif.out_ready) begin
        got_x.push_back(int'(sif.out_x));
        got_y.push_back(int'(sif.out_y));
        last_hs = k;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
      start = v.extra_start && (k + 1 == 3);
      if (start) begin
        x1 = CW'(4095 - v.x1); y1 = CW'(4095 - v.y1); x2 = CW'(4095 - v.x2);
        y2 = CW'(4095 - v.y2); x3 = CW'(4095 - v.x3); y3 = CW'(4095 - v.y3);
      end else begin
        x1 = CW'(v.x1); y1 = CW'(v.y1); x2 = CW'(v.x2);
        y2 = CW'(v.y2); x3 = CW'(v.x3); y3 = CW'(v.y3);
      end
      sif.out_ready = rdy(v.rdy_mode, k + 1);
    end
    start = 1'b0;
    sif.out_ready = 1'b1;
  endtask

  task automatic checkJob(input vec_t v);
    int mism, n, latch_err;
    checkOutput("n_points", got_x.size(), exp_x.size());
    n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
    mism = 0;
    for (int i = 0; i < n; i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) mism++;
    checkOutput("point_seq_mismatches", mism, 0);
    checkOutput("pix_count", pix_count, exp_x.size());
    latch_err = 0;
    if (int'(t_x1) != v.x1) latch_err++;
    if (int'(t_y1) != v.y1) latch_err++;
    if (int'(t_x2) != v.x2) latch_err++;
    if (int'(t_y2) != v.y2) latch_err++;
    if (int'(t_x3) != v.x3) latch_err++;
    if (int'(t_y3) != v.y3) latch_err++;
    checkOutput("t_latch_errors", latch_err, 0);
    checkOutput("probe_seq_errors", probe_err, 0);
    checkOutput("done_seen", done_cyc >= 0, 1);
    if (v.exp_done >= 0) checkOutput("done_latency", done_cyc, v.exp_done);
    if (last_hs >= 0) checkOutput("done_after_last_handshake", done_cyc > last_hs, 1);
    if (v.exp_count >= 0) begin
      checkOutput("tbl_count", got_x.size(), v.exp_count);
      if (got_x.size() > 0) begin
        checkOutput("tbl_first_x", got_x[0], v.exp_fx);
        checkOutput("tbl_first_y", got_y[0], v.exp_fy);
        checkOutput("tbl_last_x", got_x[got_x.size()-1], v.exp_lx);
        checkOutput("tbl_last_y", got_y[got_y.size()-1], v.exp_ly);
      end
    end
    @(negedge clk);
    checkOutput("done_pulse_busy_after", {done, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  vec_t vecs[5];
  vec_t rv;
  int   found, hs, perr, idx, bx, by;

  initial begin
    rst = 1'b1; start = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
    sif.out_ready = 1'b0;

    //          x1  y1  x2  y2  x3  y3 rdy ext cnt fx  fy  lx  ly  done
    vecs[0] = '{ 0,  0,  4,  0,  0,  4, 0, 0, 15,  0,  0,  0,  4, 28};
    vecs[1] = '{ 0,  0,  4,  0,  0,  4, 1, 0, 15,  0,  0,  0,  4, -1};
    vecs[2] = '{ 7,  7,  7,  7,  7,  7, 0, 0,  1,  7,  7,  7,  7,  4};
    vecs[3] = '{ 2,  1,  5,  1,  2,  1, 0, 0,  4,  2,  1,  5,  1,  7};
    vecs[4] = '{10, 10, 12, 10, 12, 12, 0, 1,  6, 10, 10, 12, 12, 12};

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", sif.out_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pix_count", pix_count, 0);
    checkOutput("rst_probe", {probe_x, probe_y}, 0);
    checkOutput("rst_t_vertices", {t_x1, t_y1, t_x2, t_y2, t_x3, t_y3}, 0);
    checkOutput("rst_out_xy", {sif.out_x, sif.out_y}, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] table vector %0d", i);
      applyStimulus(vecs[i]);
      checkJob(vecs[i]);
    end

    // Reset in the middle of a scan with a point stuck in the output register.
    $display("[TB] reset mid-scan");
    @(negedge clk);
    x1 = 0; y1 = 0; x2 = 4; y2 = 0; x3 = 0; y3 = 4;
    start = 1'b1;
    sif.out_ready = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sif.out_valid) begin
        found = 1;
        break;
      end
    end
    checkOutput("mid_valid_seen", found, 1);
    checkOutput("mid_pix_before_reset", pix_count, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_out_valid", sif.out_valid, 0);
    checkOutput("mid_rst_pix_count", pix_count, 0);
    @(negedge clk);
    rst = 1'b0;
    sif.out_ready = 1'b1;
    applyStimulus(vecs[0]);
    checkJob(vecs[0]);

    // Full-range box with a stub tester; scan two rows and abandon.
    $display("[TB] full-range box");
    stub_mode = 1'b1;
    @(negedge clk);
    x1 = 12'd4095; y1 = 12'd0; x2 = 12'd0; y2 = 12'd4095; x3 = 12'd4095; y3 = 12'd4095;
    start = 1'b1;
    sif.out_ready = 1'b1;
    hs = 0;
    perr = 0;
    for (int k = 0; k < 8200; k++) begin
      if (k >= 2) begin
        idx = k - 2;
        if (int'(probe_x) != idx % 4096 || int'(probe_y) != idx / 4096) perr++;
      end
      if (sif.out_valid && sif.out_ready) hs++;
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("full_probe_seq_errors", perr, 0);
    checkOutput("full_handshakes", hs, 3);
    checkOutput("full_pix_count", pix_count, 3);
    checkOutput("full_busy", busy, 1);
    checkOutput("full_t_x1", t_x1, 4095);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stub_mode = 1'b0;
    checkOutput("full_abandon_busy", busy, 0);

    // Randomised small triangles anywhere in the coordinate range.
    for (int r = 0; r < 20; r++) begin
      bx = $urandom_range(0, 4088);
      by = $urandom_range(0, 4088);
      rv.x1 = bx + $urandom_range(0, 7); rv.y1 = by + $urandom_range(0, 7);
      rv.x2 = bx + $urandom_range(0, 7); rv.y2 = by + $urandom_range(0, 7);
      rv.x3 = bx + $urandom_range(0, 7); rv.y3 = by + $urandom_range(0, 7);
      rv.rdy_mode    = 2;
      rv.extra_start = 1'($urandom_range(0, 1));
      rv.exp_count   = -1;
      rv.exp_fx = 0; rv.exp_fy = 0; rv.exp_lx = 0; rv.exp_ly = 0;
      rv.exp_done    = -1;
      applyStimulus(rv);
      checkJob(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
